mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owner identity and the
// read value returned when an access is aborted by timeout.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the client/memory side.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_write;
    logic [31:0] m_addr;
    logic [31:0] m_w_data;
    logic [31:0] m_r_data;
    logic        mem_ready;
    logic        arb_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_r_data, mem_ready,
        output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_req, mem_write, m_addr, m_w_data, arb_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_r_data, mem_ready,
        input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_req, mem_write, m_addr, m_w_data, arb_err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Access-cycle counter: cleared when an access starts, counts stalled cycles and
// flags expiry in the TIMEOUT-th stalled cycle. TIMEOUT of 0 never expires.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0]  LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] r_count;

    // Saturates at LAST so a disabled timeout never wraps into a false expiry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT > 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with optional timeout abort.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave arb
);

    state_t      r_state,   w_nextState;
    owner_t      r_owner,   w_owner;
    logic [31:0] r_addr,    w_addr;
    logic [31:0] r_wdata,   w_wdata;
    logic [31:0] r_ifRdata, w_ifRdata;
    logic [31:0] r_dRdata,  w_dRdata;
    logic        r_we,      w_we;
    logic        r_ifGnt,   w_ifGnt;
    logic        r_dGnt,    w_dGnt;
    logic        r_ifDone,  w_ifDone;
    logic        r_dDone,   w_dDone;
    logic        r_err,     w_err;

    logic        w_pickD;
    logic        w_timerClr;
    logic        w_timerEn;
    logic        w_expired;

`ifdef MEM_ARB_RR_EN
    logic r_favourD;

    assign w_pickD = arb.d_req && (!arb.if_req || r_favourD);

    // After any grant, the other requester is favoured on the next contention.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_favourD <= 1'b1;
        end else if (w_timerClr) begin
            r_favourD <= !w_pickD;
        end
    end
`else
    assign w_pickD = arb.d_req;
`endif

    assign w_timerClr = (r_state == IDLE) && (arb.if_req || arb.d_req);
    assign w_timerEn  = (r_state == ACCESS) && !arb.mem_ready;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timerClr),
        .i_enable  (w_timerEn),
        .o_expired (w_expired)
    );

    always_comb begin
        w_nextState = r_state;
        w_owner     = r_owner;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_we        = r_we;
        w_ifRdata   = r_ifRdata;
        w_dRdata    = r_dRdata;
        w_ifGnt     = 1'b0;
        w_dGnt      = 1'b0;
        w_ifDone    = 1'b0;
        w_dDone     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_timerClr) begin
                    w_nextState = ACCESS;
                    if (w_pickD) begin
                        w_owner = OWN_D;
                        w_addr  = arb.d_addr;
                        w_we    = arb.d_we;
                        w_wdata = arb.d_wdata;
                        w_dGnt  = 1'b1;
                    end else begin
                        w_owner = OWN_IF;
                        w_addr  = arb.if_addr;
                        w_we    = 1'b0;
                        w_wdata = '0;
                        w_ifGnt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // w_expired is gated by !mem_ready, so a same-cycle ready wins.
                if (arb.mem_ready || w_expired) begin
                    w_nextState = IDLE;
                    w_err       = !arb.mem_ready;
                    if (r_owner == OWN_D) begin
                        w_dDone = 1'b1;
                        if (!arb.mem_ready) begin
                            w_dRdata = ABORT_RDATA;
                        end else if (!r_we) begin
                            w_dRdata = arb.m_r_data;
                        end
                    end else begin
                        w_ifDone  = 1'b1;
                        w_ifRdata = arb.mem_ready ? arb.m_r_data : ABORT_RDATA;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_ifRdata <= '0;
            r_dRdata  <= '0;
            r_ifGnt   <= 1'b0;
            r_dGnt    <= 1'b0;
            r_ifDone  <= 1'b0;
            r_dDone   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_owner   <= w_owner;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_we      <= w_we;
            r_ifRdata <= w_ifRdata;
            r_dRdata  <= w_dRdata;
            r_ifGnt   <= w_ifGnt;
            r_dGnt    <= w_dGnt;
            r_ifDone  <= w_ifDone;
            r_dDone   <= w_dDone;
            r_err     <= w_err;
        end
    end

    assign arb.if_gnt    = r_ifGnt;
    assign arb.d_gnt     = r_dGnt;
    assign arb.if_done   = r_ifDone;
    assign arb.d_done    = r_dDone;
    assign arb.if_rdata  = r_ifRdata;
    assign arb.d_rdata   = r_dRdata;
    assign arb.arb_err   = r_err;
    assign arb.mem_req   = (r_state == ACCESS);
    assign arb.mem_write = (r_state == ACCESS) && r_we;
    assign arb.m_addr    = r_addr;
    assign arb.m_w_data  = r_wdata;

endmodule
